// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand-forwarding selects and load-use stall/bubble control.
// Optional macro FWD_STATS_EN adds saturating Stall_Count / Fwd_Count outputs.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5
`ifdef FWD_STATS_EN
    , parameter int STAT_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Id_Valid,
    input  logic [REG_ADDR_W-1:0] Id_Rs1,
    input  logic [REG_ADDR_W-1:0] Id_Rs2,
    input  logic [REG_ADDR_W-1:0] Id_Rd,
    input  logic                  Id_UsesRs1,
    input  logic                  Id_UsesRs2,
    input  logic                  Id_RegWrite,
    input  logic                  Id_MemRead,
    input  logic                  Flush,
    output logic                  Stall,
    output logic [1:0]            Sel_A,
    output logic [1:0]            Sel_B,
`ifdef FWD_STATS_EN
    output logic [STAT_W-1:0]     Stall_Count,
    output logic [STAT_W-1:0]     Fwd_Count,
`endif
    output logic                  Ex_Valid
);
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
    } dst_t;

    typedef struct packed {
        dst_t                  dst;
        logic                  memread;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  uses1;
        logic                  uses2;
    } ex_t;

    ex_t  ex_q, ex_d;
    dst_t mem_q, mem_d, wb_q, wb_d;
    logic mem_load_q, mem_load_d;

    // A load sitting in MEM that matches EX means the stall failed; fall back to the
    // regfile rather than forwarding a stale WB value or an address.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs, input logic uses,
                                           input dst_t m, input logic m_load, input dst_t w);
        logic m_hit, w_hit;
        m_hit = m.valid & m.regwrite & (m.rd != '0) & (m.rd == rs);
        w_hit = w.valid & w.regwrite & (w.rd != '0) & (w.rd == rs);
        return !uses ? 2'd0 : m_hit ? (m_load ? 2'd0 : 2'd1) : w_hit ? 2'd2 : 2'd0;
    endfunction

    // Load-use detection, next-stage records and forwarding selects.
    always_comb begin
        Stall = Id_Valid & !Flush & ex_q.dst.valid & ex_q.memread & (ex_q.dst.rd != '0) &
                ((Id_UsesRs1 & (Id_Rs1 == ex_q.dst.rd)) | (Id_UsesRs2 & (Id_Rs2 == ex_q.dst.rd)));
        ex_d.dst.valid    = Id_Valid & !Flush & !Stall;
        ex_d.dst.rd       = Id_Rd;
        ex_d.dst.regwrite = Id_RegWrite;
        ex_d.memread      = Id_MemRead;
        ex_d.rs1          = Id_Rs1;
        ex_d.rs2          = Id_Rs2;
        ex_d.uses1        = Id_UsesRs1;
        ex_d.uses2        = Id_UsesRs2;
        mem_d             = ex_q.dst;
        mem_load_d        = ex_q.memread;
        wb_d              = mem_q;
        Sel_A    = fwd_sel(ex_q.rs1, ex_q.dst.valid & ex_q.uses1, mem_q, mem_load_q, wb_q);
        Sel_B    = fwd_sel(ex_q.rs2, ex_q.dst.valid & ex_q.uses2, mem_q, mem_load_q, wb_q);
        Ex_Valid = ex_q.dst.valid;
    end

    // Pipeline advance; reset only needs to kill the valid bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q.dst.valid <= 1'b0;
            mem_q.valid    <= 1'b0;
            wb_q.valid     <= 1'b0;
        end else begin
            ex_q       <= ex_d;
            mem_q      <= mem_d;
            mem_load_q <= mem_load_d;
            wb_q       <= wb_d;
        end
    end

`ifdef FWD_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

    // Saturating event counters; a cycle forwarding on both operands counts once.
    always_comb begin
        stall_cnt_d = (Stall & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        fwd_cnt_d   = (ex_q.dst.valid & ((Sel_A != 2'd0) | (Sel_B != 2'd0)) & ~&fwd_cnt_q) ?
                      fwd_cnt_q + 1'b1 : fwd_cnt_q;
        Stall_Count = stall_cnt_q;
        Fwd_Count   = fwd_cnt_q;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed and random checks of fwd_hazard_ctrl against an instruction-history model.
module tb_fwd_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Id_Valid = 1'b0;
    logic [4:0] Id_Rs1 = '0, Id_Rs2 = '0, Id_Rd = '0;
    logic       Id_UsesRs1 = 1'b0, Id_UsesRs2 = 1'b0, Id_RegWrite = 1'b0, Id_MemRead = 1'b0;
    logic       Flush = 1'b0;
    logic       Stall, Ex_Valid;
    logic [1:0] Sel_A, Sel_B;
`ifdef FWD_STATS_EN
    logic [15:0] Stall_Count, Fwd_Count;
`endif

    fwd_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Id_Valid(Id_Valid), .Id_Rs1(Id_Rs1), .Id_Rs2(Id_Rs2),
        .Id_Rd(Id_Rd), .Id_UsesRs1(Id_UsesRs1), .Id_UsesRs2(Id_UsesRs2),
        .Id_RegWrite(Id_RegWrite), .Id_MemRead(Id_MemRead), .Flush(Flush),
        .Stall(Stall), .Sel_A(Sel_A), .Sel_B(Sel_B),
`ifdef FWD_STATS_EN
        .Stall_Count(Stall_Count), .Fwd_Count(Fwd_Count),
`endif
        .Ex_Valid(Ex_Valid)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit armed = 1'b0;

    // Issued-instruction history: hist[0] is the instruction now executing, hist[1] the
    // one issued a cycle earlier, hist[2] two cycles earlier.
    typedef struct {
        bit       v;
        bit [4:0] rd, rs1, rs2;
        bit       rw, ld, u1, u2;
    } ins_t;
    ins_t hist[3];
    int   m_stalls = 0;
    int   m_fwds = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // The instruction in decode needs a value a load in execute has not produced yet.
    function automatic bit m_stall();
        return Id_Valid && !Flush && hist[0].v && hist[0].ld && hist[0].rd != 0 &&
               ((Id_UsesRs1 && Id_Rs1 == hist[0].rd) || (Id_UsesRs2 && Id_Rs2 == hist[0].rd));
    endfunction

    // Find the most recent older producer of rs; distance 1 forwards the ALU result,
    // distance 2 the writeback value; a load at distance 1 has no usable value.
    function automatic bit [1:0] m_sel(input bit [4:0] rs, input bit uses);
        if (!hist[0].v || !uses || rs == 0) return 2'd0;
        for (int k = 1; k <= 2; k++)
            if (hist[k].v && hist[k].rw && hist[k].rd == rs)
                return (k == 1 && hist[k].ld) ? 2'd0 : 2'(k);
        return 2'd0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) hist[k].v = 1'b0;
            m_stalls = 0;
            m_fwds = 0;
        end else begin
            if (m_stall() && m_stalls < 65535) m_stalls++;
            if ((m_sel(hist[0].rs1, hist[0].u1) != 0 || m_sel(hist[0].rs2, hist[0].u2) != 0) &&
                m_fwds < 65535) m_fwds++;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0].v   = Id_Valid && !Flush && !m_stall();
            hist[0].rd  = Id_Rd;
            hist[0].rs1 = Id_Rs1;
            hist[0].rs2 = Id_Rs2;
            hist[0].rw  = Id_RegWrite;
            hist[0].ld  = Id_MemRead;
            hist[0].u1  = Id_UsesRs1;
            hist[0].u2  = Id_UsesRs2;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("stall", Stall, m_stall());
            chk("sel_a", Sel_A, m_sel(hist[0].rs1, hist[0].u1));
            chk("sel_b", Sel_B, m_sel(hist[0].rs2, hist[0].u2));
            chk("ex_valid", Ex_Valid, hist[0].v);
`ifdef FWD_STATS_EN
            chk("stall_count", Stall_Count, m_stalls);
            chk("fwd_count", Fwd_Count, m_fwds);
`endif
            if (hist[0].v && hist[1].v && hist[1].ld && hist[1].rd != 0 &&
                ((hist[0].u1 && hist[0].rs1 == hist[1].rd) || (hist[0].u2 && hist[0].rs2 == hist[1].rd))) begin
                n_fail++;
                $display("FAIL load_in_mem: dependent instruction reached EX behind a load at %0t", $time);
            end
        end
    end

    task automatic put(input bit v, input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] rd,
                       input bit u1, input bit u2, input bit rw, input bit ld, input bit fl);
        @(posedge clk);
        #1;
        Id_Valid = v; Id_Rs1 = r1; Id_Rs2 = r2; Id_Rd = rd;
        Id_UsesRs1 = u1; Id_UsesRs2 = u2; Id_RegWrite = rw; Id_MemRead = ld; Flush = fl;
    endtask

    task automatic bubble();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic put_rand();
        bit ld;
        ld = ($urandom_range(0, 3) == 0);
        put($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), ld | 1'($urandom), ld,
            $urandom_range(0, 9) == 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        Id_Valid = 1'b0; Flush = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_stall"}, Stall, 0);
        chk({nm, "_sel_a"}, Sel_A, 0);
        chk({nm, "_sel_b"}, Sel_B, 0);
        chk({nm, "_ex_valid"}, Ex_Valid, 0);
`ifdef FWD_STATS_EN
        chk({nm, "_stall_count"}, Stall_Count, 0);
        chk({nm, "_fwd_count"}, Fwd_Count, 0);
`endif
    endtask

    initial begin
        repeat (2) put_rand();
        @(negedge clk);
        chk_idle("reset");
        armed = 1'b1;
        rst_n = 1'b1;

        // add x5,x1,x2 ; sub x6,x5,x3
        repeat (3) bubble();
        put(1, 1, 2, 5, 1, 1, 1, 0, 0);
        put(1, 5, 3, 6, 1, 1, 1, 0, 0);
        @(negedge clk); chk("b2b_stall", Stall, 0);
        bubble();
        @(negedge clk); chk("b2b_sel_a", Sel_A, 1); chk("b2b_sel_b", Sel_B, 0); chk("b2b_stall2", Stall, 0);

        // addi x5,x0,1 ; add x11,x12,x13 ; or x7,x4,x5
        repeat (3) bubble();
        put(1, 0, 0, 5, 1, 0, 1, 0, 0);
        put(1, 12, 13, 11, 1, 1, 1, 0, 0);
        put(1, 4, 5, 7, 1, 1, 1, 0, 0);
        bubble();
        @(negedge clk); chk("d2_sel_a", Sel_A, 0); chk("d2_sel_b", Sel_B, 2);

        // lw x7,0(x1) ; add x8,x7,x7 (held in decode during the stall)
        do_reset();
        put(1, 1, 0, 7, 1, 0, 1, 1, 0);
        put(1, 7, 7, 8, 1, 1, 1, 0, 0);
        @(negedge clk); chk("lu_stall", Stall, 1);
        put(1, 7, 7, 8, 1, 1, 1, 0, 0);
        @(negedge clk); chk("lu_stall_once", Stall, 0); chk("lu_bubble", Ex_Valid, 0);
        bubble();
        @(negedge clk); chk("lu_sel_a", Sel_A, 2); chk("lu_sel_b", Sel_B, 2); chk("lu_ex_valid", Ex_Valid, 1);
`ifdef FWD_STATS_EN
        chk("lu_stall_count", Stall_Count, 1);
`endif
        bubble();
`ifdef FWD_STATS_EN
        @(negedge clk); chk("lu_fwd_count", Fwd_Count, 1); chk("lu_stall_count2", Stall_Count, 1);
`endif

        // addi x9,x0,1 ; addi x9,x9,1 ; add x10,x9,x0
        repeat (3) bubble();
        put(1, 0, 0, 9, 1, 0, 1, 0, 0);
        put(1, 9, 0, 9, 1, 0, 1, 0, 0);
        put(1, 9, 0, 10, 1, 1, 1, 0, 0);
        bubble();
        @(negedge clk); chk("prio_sel_a", Sel_A, 1); chk("prio_sel_b", Sel_B, 0);

        // addi x0,x1,1 ; add x2,x0,x0
        repeat (3) bubble();
        put(1, 1, 0, 0, 1, 0, 1, 0, 0);
        put(1, 0, 0, 2, 1, 1, 1, 0, 0);
        bubble();
        @(negedge clk); chk("x0_sel_a", Sel_A, 0); chk("x0_sel_b", Sel_B, 0);

        // lw x7 ; dependent add arriving with Flush
        do_reset();
        put(1, 1, 0, 7, 1, 0, 1, 1, 0);
        put(1, 7, 7, 8, 1, 1, 1, 0, 1);
        @(negedge clk); chk("flush_stall", Stall, 0);
        bubble();
        @(negedge clk); chk("flush_ex_valid", Ex_Valid, 0);

        // reset while stalled
        repeat (3) bubble();
        put(1, 1, 0, 7, 1, 0, 1, 1, 0);
        put(1, 7, 7, 8, 1, 1, 1, 0, 0);
        @(negedge clk); chk("rst_stall_pre", Stall, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("rst_mid_stall");
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            put_rand();
            rst_n = ($urandom_range(0, 63) != 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) bubble();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
